// File: rtl/cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_pkg                                                         |
// | Brief    : Shared defaults and FSM state encoding for the CIC comb block.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package cic_pkg;

    localparam int c_W_DEF = 16;
    localparam int c_R_DEF = 8;
    localparam int c_M_DEF = 3;

    typedef logic [0:0] state_t;

    localparam state_t c_PRIME = 1'b0;
    localparam state_t c_RUN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/comb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : comb_stage                                                      |
// | Brief    : One token-driven comb section: y = x - x(previous token).      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module comb_stage
    import cic_pkg::*;
#(
    parameter int W = c_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_x,
    input  logic         i_tok,
    output logic [W-1:0] o_y,
    output logic         o_tok
);

    logic [W-1:0] r_dly;
    logic [W-1:0] r_y;
    logic         r_tok;

    // Subtraction wraps modulo 2^W so integrator overflow cancels out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= '0;
            r_y   <= '0;
            r_tok <= 1'b0;
        end else begin
            r_tok <= i_tok;
            if (i_tok) begin
                r_dly <= i_x;
                r_y   <= i_x - r_dly;
            end
        end
    end

    assign o_y   = r_y;
    assign o_tok = r_tok;

endmodule
`default_nettype wire

// File: rtl/cic_comb_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cic_comb_decimator                                              |
// | Brief    : Decimate-by-R sampler followed by an M-stage comb pipeline.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int W = c_W_DEF,
    parameter int R = c_R_DEF,
    parameter int M = c_M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         overrun,
    input  logic         overrun_clr
);

    localparam int c_CW = (R > 1) ? $clog2(R) : 1;
    localparam int c_PW = 3;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(R - 1);
    localparam logic [c_PW-1:0] c_PLAST = c_PW'(M - 1);

    logic [c_CW-1:0]       r_cnt;
    logic [W-1:0]          r_s0;
    logic                  r_t0;
    logic                  w_strobe;
    logic [M:0][W-1:0]     w_x;
    logic [M:0]            w_tok;
    logic                  w_res;
    logic                  w_load;
    logic                  w_hs;
    logic                  w_ovr_set;
    state_t                r_state;
    logic [c_PW-1:0]       r_prime_cnt;
    logic [W-1:0]          r_dout;
    logic                  r_dout_valid;
    logic                  r_overrun;

    assign w_strobe = din_valid && !rst && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_s0  <= '0;
            r_t0  <= 1'b0;
        end else begin
            r_t0 <= w_strobe;
            if (din_valid) begin
                r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
            end
            if (w_strobe) begin
                r_s0 <= din;
            end
        end
    end

    assign w_x[0]   = r_s0;
    assign w_tok[0] = r_t0;

    for (genvar k = 0; k < M; k++) begin : g_stage
        comb_stage #(
            .W (W)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .i_x   (w_x[k]),
            .i_tok (w_tok[k]),
            .o_y   (w_x[k+1]),
            .o_tok (w_tok[k+1])
        );
    end

    assign w_res     = w_tok[M];
    assign w_load    = w_res && (r_state == c_RUN);
    assign w_hs      = r_dout_valid && dout_ready;
    assign w_ovr_set = w_load && r_dout_valid && !dout_ready;

    // The first M results still carry zero-initialised delay history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_PRIME;
            r_prime_cnt  <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_res && (r_state == c_PRIME)) begin
                if (r_prime_cnt == c_PLAST) begin
                    r_state     <= c_RUN;
                    r_prime_cnt <= '0;
                end else begin
                    r_prime_cnt <= r_prime_cnt + 1'b1;
                end
            end
            if (w_load) begin
                r_dout       <= w_x[M];
                r_dout_valid <= 1'b1;
            end else if (w_hs) begin
                r_dout_valid <= 1'b0;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_cic_comb_decimator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cic_comb_decimator                                           |
// | Brief    : Directed bench with reference comb model and result scoreboard. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_cic_comb_decimator;

    localparam int W = 16;
    localparam int R = 8;
    localparam int M = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         overrun;
    logic         overrun_clr;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    bit           rnd_mode = 1'b0;
    logic [W-1:0] exp_q[$];
    int           rise_q[$];

    int           m_cnt = 0;
    int           m_prime = 0;
    int           m_strobe_cyc = -1;
    logic [W-1:0] m_z [M];
    logic [W-1:0] m_x;
    logic [W-1:0] m_y;
    logic         prev_dv = 1'b0;

    always #5 clk = ~clk;

    cic_comb_decimator #(
        .W (W),
        .R (R),
        .M (M)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) din = W'($urandom);
    endtask

    task automatic wait_dv(input int max, input string tag);
        for (int i = 0; i < max && !dout_valid; i++) tick();
        check(tag, {31'b0, dout_valid}, 32'd1);
    endtask

    // Reference: decimate, run M modular differences, drop the first M results.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_cnt   = 0;
            m_prime = 0;
            for (int k = 0; k < M; k++) m_z[k] = '0;
            exp_q.delete();
        end else if (din_valid) begin
            if (m_cnt == R - 1) begin
                m_cnt        = 0;
                m_strobe_cyc = cyc;
                m_x          = din;
                for (int k = 0; k < M; k++) begin
                    m_y    = m_x - m_z[k];
                    m_z[k] = m_x;
                    m_x    = m_y;
                end
                if (m_prime < M) m_prime++;
                else exp_q.push_back(m_x);
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (dout_valid && !prev_dv) rise_q.push_back(cyc);
        prev_dv = dout_valid;
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) check("spurious_result", {31'b0, dout_valid}, 32'd0);
            else check("dout_value", {16'b0, dout}, {16'b0, exp_q.pop_front()});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] held;
        int           n;
        int           n_seen;

        rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b1; overrun_clr = 1'b0;
        repeat (3) tick();
        check("rst_dout_valid", {31'b0, dout_valid}, 32'd0);
        check("rst_dout", {16'b0, dout}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);

        // Constant input: three results primed away, then zeros.
        rst = 1'b0; din = 16'h1234; din_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 35) check("latency_early", {31'b0, dout_valid}, 32'd0);
            if (i == 36) begin
                check("first_valid", {31'b0, dout_valid}, 32'd1);
                check("const_dout", {16'b0, dout}, 32'd0);
            end
        end

        // Ramp of +5 crossing the 16-bit wrap.
        din = 16'hFFF0;
        for (int i = 0; i < 64; i++) begin
            tick();
            din = din + 16'd5;
        end

        // 50% din_valid with random data.
        rise_q.delete();
        for (int i = 0; i < 160; i++) begin
            din_valid = (i % 2 == 0);
            din = W'($urandom);
            tick();
        end
        n = rise_q.size();
        check("toggle_rise_count", {31'b0, n >= 3}, 32'd1);
        if (n >= 3) begin
            check("toggle_spacing_a", rise_q[n-1] - rise_q[n-2], 32'd16);
            check("toggle_spacing_b", rise_q[n-2] - rise_q[n-3], 32'd16);
        end

        // Overrun: hold ready low across two results.
        din_valid = 1'b1; rnd_mode = 1'b1; dout_ready = 1'b0;
        wait_dv(20, "ovr_first_valid");
        held = dout;
        repeat (3) tick();
        check("hold_stable", {16'b0, dout}, {16'b0, held});
        for (int i = 0; i < 12 && !overrun; i++) tick();
        check("overrun_set", {31'b0, overrun}, 32'd1);
        check("overrun_valid", {31'b0, dout_valid}, 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        dout_ready = 1'b1; overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("overrun_cleared", {31'b0, overrun}, 32'd0);
        check("valid_cleared", {31'b0, dout_valid}, 32'd0);

        // Handshake and new result on the same edge.
        dout_ready = 1'b0;
        wait_dv(20, "hs_first_valid");
        repeat (7) tick();
        dout_ready = 1'b1;
        tick();
        check("hs_valid_kept", {31'b0, dout_valid}, 32'd1);
        check("hs_no_overrun", {31'b0, overrun}, 32'd0);
        tick();
        check("hs_valid_clear", {31'b0, dout_valid}, 32'd0);

        // Reset while a token sits in the comb pipeline.
        for (int i = 0; i < 12 && m_strobe_cyc != cyc; i++) tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_valid", {31'b0, dout_valid}, 32'd0);
        check("rstmid_dout", {16'b0, dout}, 32'd0);
        check("rstmid_overrun", {31'b0, overrun}, 32'd0);
        n_seen = 0;
        for (int i = 1; i <= 36; i++) begin
            tick();
            if (i < 36 && dout_valid) n_seen++;
            if (i == 36) check("rstmid_first_valid", {31'b0, dout_valid}, 32'd1);
        end
        check("rstmid_suppressed", n_seen, 32'd0);

        din_valid = 1'b0; rnd_mode = 1'b0;
        repeat (10) tick();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
